// File: rtl/bitwise_stream_pkg.sv
// Shared encodings for the bitwise stream datapath: op select codes and FSM states.
package bitwise_stream_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational bitwise op mux; also instantiated by the ALU.
module bitwise_op_core
  import bitwise_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = a & b;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      OP_PASS: r = a;
      default: r = a & b;
    endcase
  end

endmodule

// File: rtl/bitwise_stream_unit.sv
// Registered valid/ready bitwise unit; folds multi-beat bursts into one result.
module bitwise_stream_unit
  import bitwise_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_beats
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt_nxt;
  logic             fire;

  // Inside a burst the running partial result replaces in_b.
  assign opnd_b   = (state == ST_IDLE) ? in_b : acc;
  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;
  assign cnt_nxt  = (state == ST_IDLE) ? CNT_W'(1) :
                    (&cnt)             ? cnt : cnt + CNT_W'(1);

  bitwise_op_core #(.WIDTH(WIDTH)) u_core (
    .a  (in_a),
    .b  (opnd_b),
    .op (in_op),
    .r  (r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_beats <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (fire) begin
        if (in_last) begin
          // A same-cycle pop and load keeps out_valid high with new data.
          out_valid <= 1'b1;
          out_data  <= r;
          out_zero  <= (r == '0);
          out_beats <= cnt_nxt;
          state     <= ST_IDLE;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc   <= r;
          cnt   <= cnt_nxt;
          state <= ST_ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// Directed bench for bitwise_stream_unit; a CNT_W=2 twin shares inputs for saturation.
module tb_bitwise_stream_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        in_ready, out_valid, out_zero;
  logic [15:0] out_data;
  logic [7:0]  out_beats;
  logic        in_ready2, out_valid2, out_zero2;
  logic [15:0] out_data2;
  logic [1:0]  out_beats2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bitwise_stream_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_beats(out_beats)
  );

  bitwise_stream_unit #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_zero(out_zero2), .out_beats(out_beats2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be accepted, then sample point.
  task automatic send_beat(input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic last);
    int waited = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_last = last;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = 3'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    n_vec++; if (out_beats !== 8'd0) begin n_err++; $display("FAIL rst_out_beats: got %0d want 0", out_beats); end
    n_vec++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL rst_out_zero: got %0b want 0", out_zero); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    send_beat(3'd0, 16'hF0F0, 16'hFF00, 1'b1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL and_valid: got %0b want 1", out_valid); end
    n_vec++; if (out_data !== 16'hF000) begin n_err++; $display("FAIL and_data: got %h want F000", out_data); end
    n_vec++; if (out_beats !== 8'd1) begin n_err++; $display("FAIL and_beats: got %0d want 1", out_beats); end
    n_vec++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL and_zero: got %0b want 0", out_zero); end
    send_beat(3'd4, 16'hFFFF, 16'h0000, 1'b1);
    n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL nor_data: got %h want 0000", out_data); end
    n_vec++; if (out_zero !== 1'b1) begin n_err++; $display("FAIL nor_zero: got %0b want 1", out_zero); end
    send_beat(3'd6, 16'h1234, 16'hFFFF, 1'b1);
    n_vec++; if (out_data !== 16'hEDCB) begin n_err++; $display("FAIL nota_data: got %h want EDCB", out_data); end
    send_beat(3'd5, 16'h00FF, 16'h0F0F, 1'b1);
    n_vec++; if (out_data !== 16'hF00F) begin n_err++; $display("FAIL xnor_data: got %h want F00F", out_data); end
    send_beat(3'd3, 16'h00FF, 16'h0F0F, 1'b1);
    n_vec++; if (out_data !== 16'hFFF0) begin n_err++; $display("FAIL nand_data: got %h want FFF0", out_data); end
    send_beat(3'd7, 16'hBEEF, 16'h0000, 1'b1);
    n_vec++; if (out_data !== 16'hBEEF) begin n_err++; $display("FAIL pass_data: got %h want BEEF", out_data); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pop_clears_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_xor_burst();
    logic [15:0] as [4] = '{16'h0001, 16'h0004, 16'h0008, 16'h0010};
    for (int i = 0; i < 4; i++) begin
      send_beat(3'd2, as[i], (i == 0) ? 16'h0002 : 16'h0000, i == 3);
      if (i < 3) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL xor_midburst_valid beat %0d: got %0b want 0", i, out_valid); end
      end
    end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL xor_valid: got %0b want 1", out_valid); end
    n_vec++; if (out_data !== 16'h001F) begin n_err++; $display("FAIL xor_data: got %h want 001F", out_data); end
    n_vec++; if (out_beats !== 8'd4) begin n_err++; $display("FAIL xor_beats: got %0d want 4", out_beats); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL xor_single_pulse: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_beat(3'd0, 16'hFFFF, 16'h00FF, 1'b1);
    n_vec++; if (out_data !== 16'h00FF) begin n_err++; $display("FAIL bp_first_data: got %h want 00FF", out_data); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %0b want 0", in_ready); end
    in_valid = 1'b1; in_op = 3'd1; in_a = 16'h0F00; in_b = 16'h00F0; in_last = 1'b1;
    repeat (2) tick();
    n_vec++; if (out_data !== 16'h00FF) begin n_err++; $display("FAIL bp_hold_data: got %h want 00FF", out_data); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %0b want 1", out_valid); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_comb: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid: got %0b want 1", out_valid); end
    n_vec++; if (out_data !== 16'h0FF0) begin n_err++; $display("FAIL bp_second_data: got %h want 0FF0", out_data); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++)
      send_beat(3'd0, 16'hFFFF, 16'hFFFF, i == 4);
    n_vec++; if (out_data2 !== 16'hFFFF) begin n_err++; $display("FAIL sat_data: got %h want FFFF", out_data2); end
    n_vec++; if (out_beats2 !== 2'd3) begin n_err++; $display("FAIL sat_beats: got %0d want 3", out_beats2); end
    n_vec++; if (out_beats !== 8'd5) begin n_err++; $display("FAIL nosat_beats: got %0d want 5", out_beats); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    send_beat(3'd1, 16'h0001, 16'h0100, 1'b0);
    send_beat(3'd1, 16'h0002, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %0b want 0", out_valid); end
    rst_n = 1'b1;
    tick();
    send_beat(3'd1, 16'h0004, 16'h0008, 1'b1);
    n_vec++; if (out_data !== 16'h000C) begin n_err++; $display("FAIL midrst_data: got %h want 000C", out_data); end
    n_vec++; if (out_beats !== 8'd1) begin n_err++; $display("FAIL midrst_beats: got %0d want 1", out_beats); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_xor_burst();
    test_back_to_back();
    test_saturation();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
